// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv2 datapath: tap/weight/product/accumulator widths
// and the output rescale (ReLU + saturation) function.
package conv_pkg;

  localparam int unsigned FILTER_SIZE = 3;
  localparam int unsigned KERNEL_TAPS = FILTER_SIZE * FILTER_SIZE;
  localparam int unsigned DATA_BITS   = 32;
  localparam int unsigned WEIGHT_BITS = 16;
  localparam int unsigned FRAC_BITS   = 8;
  localparam int unsigned PROD_BITS   = DATA_BITS + WEIGHT_BITS;
  localparam int unsigned RSUM_BITS   = PROD_BITS + 2;
  localparam int unsigned ACC_BITS    = PROD_BITS + 4;

  typedef logic signed [DATA_BITS-1:0]   data_t;
  typedef logic signed [WEIGHT_BITS-1:0] weight_t;
  typedef logic signed [PROD_BITS-1:0]   prod_t;
  typedef logic signed [RSUM_BITS-1:0]   rsum_t;
  typedef logic signed [ACC_BITS-1:0]    acc_t;

  localparam data_t DATA_MAX = data_t'({1'b0, {(DATA_BITS - 1){1'b1}}});

  // Floor-rescale the accumulator, then clamp into [0, DATA_MAX].
  function automatic data_t sat_relu(input acc_t acc);
    acc_t y;
    y = acc >>> FRAC_BITS;
    if (y[ACC_BITS-1]) return '0;
    if (y > acc_t'(DATA_MAX)) return DATA_MAX;
    return data_t'(y[DATA_BITS-1:0]);
  endfunction

endpackage

// File: rtl/conv2_mac_tree.sv
// Four-register 3x3 MAC datapath: products, row sums, accumulate with bias, rescale/clamp.
// A window presented with i_valid at edge N appears on o_data/o_valid after edge N+3.
module conv2_mac_tree
  import conv_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_valid,
  input  logic [KERNEL_TAPS-1:0][DATA_BITS-1:0]   i_taps,
  input  logic [KERNEL_TAPS-1:0][WEIGHT_BITS-1:0] i_weights,
  input  logic [DATA_BITS-1:0]                    i_bias,
  output logic                                    o_valid_acc,
  output logic                                    o_valid,
  output logic [DATA_BITS-1:0]                    o_data
);

  prod_t r_prod [KERNEL_TAPS];
  rsum_t r_rsum [FILTER_SIZE];
  acc_t  r_acc;
  logic  r_v1, r_v2, r_v3;
  rsum_t w_rsum [FILTER_SIZE];
  acc_t  w_acc;

  always_comb begin
    for (int j = 0; j < FILTER_SIZE; j++) begin
      w_rsum[j] = '0;
      for (int k = 0; k < FILTER_SIZE; k++) begin
        w_rsum[j] = w_rsum[j] + rsum_t'(r_prod[FILTER_SIZE*j + k]);
      end
    end
  end

  // Bias is aligned to the weight fixed-point scale before joining the sum.
  always_comb begin
    w_acc = acc_t'(r_rsum[0]) + acc_t'(r_rsum[1]) + acc_t'(r_rsum[2]) +
            (acc_t'(data_t'(i_bias)) <<< FRAC_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      r_acc   <= '0;
      for (int i = 0; i < KERNEL_TAPS; i++) r_prod[i] <= '0;
      for (int j = 0; j < FILTER_SIZE; j++) r_rsum[j] <= '0;
    end else begin
      r_v1    <= i_valid;
      r_v2    <= r_v1;
      r_v3    <= r_v2;
      o_valid <= r_v3;
      if (i_valid) begin
        for (int i = 0; i < KERNEL_TAPS; i++) begin
          r_prod[i] <= prod_t'(data_t'(i_taps[i])) * prod_t'(weight_t'(i_weights[i]));
        end
      end
      if (r_v1) begin
        for (int j = 0; j < FILTER_SIZE; j++) r_rsum[j] <= w_rsum[j];
      end
      if (r_v2) r_acc <= w_acc;
      if (r_v3) o_data <= sat_relu(r_acc);
    end
  end

  assign o_valid_acc = r_v3;

endmodule

// File: rtl/conv2_calc.sv
// conv2 window consumer: weight regfile and load sequencing, acceptance gating,
// MAC datapath and output position / end-of-frame tracking.
module conv2_calc
  import conv_pkg::*;
#(
  parameter int unsigned OUT_W = 13,
  parameter int unsigned OUT_H = 17
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  w_load,
  input  logic [WEIGHT_BITS-1:0]                w_data,
  input  logic [DATA_BITS-1:0]                  bias,
  input  logic [KERNEL_TAPS-1:0][DATA_BITS-1:0] data_in,
  input  logic                                  valid_in,
  output logic [DATA_BITS-1:0]                  data_out,
  output logic                                  valid_out,
  output logic                                  frame_done
);

  localparam int unsigned CNT_BITS = $clog2(KERNEL_TAPS);
  localparam int unsigned COL_BITS = $clog2(OUT_W);
  localparam int unsigned ROW_BITS = $clog2(OUT_H);

  logic [KERNEL_TAPS-1:0][WEIGHT_BITS-1:0] r_weight;
  logic [CNT_BITS-1:0]                     r_w_cnt;
  logic                                    r_weights_ready;
  logic [COL_BITS-1:0]                     r_col;
  logic [ROW_BITS-1:0]                     r_row;
  logic                                    r_frame_done;
  logic                                    w_accept;
  logic                                    w_valid_acc;
  logic                                    w_col_last;
  logic                                    w_row_last;

  // Any write in progress blocks acceptance; a dropped partial load invalidates the kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight        <= '0;
      r_w_cnt         <= '0;
      r_weights_ready <= 1'b0;
    end else if (w_load) begin
      r_weight[r_w_cnt] <= w_data;
      if (r_w_cnt == CNT_BITS'(KERNEL_TAPS - 1)) begin
        r_w_cnt         <= '0;
        r_weights_ready <= 1'b1;
      end else begin
        r_w_cnt         <= r_w_cnt + 1'b1;
        r_weights_ready <= 1'b0;
      end
    end else if (r_w_cnt != '0) begin
      r_w_cnt         <= '0;
      r_weights_ready <= 1'b0;
    end
  end

  assign w_accept = valid_in && r_weights_ready && !w_load;

  conv2_mac_tree u_mac_tree (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (w_accept),
    .i_taps      (data_in),
    .i_weights   (r_weight),
    .i_bias      (bias),
    .o_valid_acc (w_valid_acc),
    .o_valid     (valid_out),
    .o_data      (data_out)
  );

  assign w_col_last = (r_col == COL_BITS'(OUT_W - 1));
  assign w_row_last = (r_row == ROW_BITS'(OUT_H - 1));

  // Counters advance with the pixel entering the output register so frame_done lines up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_valid_acc && w_col_last && w_row_last;
      if (w_valid_acc) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv2_calc.sv
// Self-checking bench for conv2_calc: directed vector table plus randomized frames,
// every cycle compared against an arithmetic reference model.
module tb_conv2_calc;

  localparam int FRAME = 13 * 17;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                w_load;
  logic [15:0]         w_data;
  logic [31:0]         bias;
  logic [8:0][31:0]    data_in;
  logic                valid_in;
  logic [31:0]         data_out;
  logic                valid_out;
  logic                frame_done;

  always #5 clk = ~clk;

  conv2_calc #(.OUT_W(13), .OUT_H(17)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_load     (w_load),
    .w_data     (w_data),
    .bias       (bias),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  typedef struct {
    int          due;
    logic [31:0] px;
  } exp_t;

  typedef struct {
    string            name;
    logic [8:0][15:0] w;
    logic [8:0][31:0] taps;
    logic [31:0]      b;
    logic [31:0]      expect_px;
  } vec_t;

  logic [8:0][15:0] m_w;
  int               m_cnt;
  bit               m_ready;
  exp_t             q[$];
  int               cyc;
  logic [31:0]      m_last;
  int               m_nout;
  int               n_cmp, n_err;
  int               n_valid, n_fd;

  function automatic logic [31:0] model_px(input logic [8:0][31:0] t, input logic [8:0][15:0] w,
                                           input logic [31:0] b);
    longint s;
    longint y;
    s = longint'($signed(b)) * 256;
    for (int i = 0; i < 9; i++) s += longint'($signed(t[i])) * longint'($signed(w[i]));
    y = s >>> 8;
    if (y < 0) return 32'd0;
    if (y > 64'sd2147483647) return 32'h7fff_ffff;
    return y[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    bit          exp_valid;
    bit          exp_fd;
    exp_t        e;
    if (valid_in && m_ready && !w_load) q.push_back('{cyc + 4, model_px(data_in, m_w, bias)});
    if (w_load) begin
      m_w[m_cnt] = w_data;
      if (m_cnt == 8) begin
        m_cnt   = 0;
        m_ready = 1'b1;
      end else begin
        m_cnt++;
        m_ready = 1'b0;
      end
    end else if (m_cnt != 0) begin
      m_cnt   = 0;
      m_ready = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e         = q.pop_front();
      exp_valid = 1'b1;
      m_last    = e.px;
      m_nout++;
      exp_fd    = (m_nout % FRAME) == 0;
    end
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    check("data_out", data_out, m_last);
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (valid_out) n_valid++;
    if (frame_done) n_fd++;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    w_load   = 1'b0;
    rst_n    = 1'b0;
    #1;
    q.delete();
    m_w     = '0;
    m_cnt   = 0;
    m_ready = 1'b0;
    m_last  = '0;
    m_nout  = 0;
    check("reset valid_out", 32'(valid_out), 32'd0);
    check("reset data_out", data_out, 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [8:0][15:0] w, input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      w_load = 1'b1;
      w_data = w[i];
      step();
    end
    w_load = 1'b0;
  endtask

  task automatic rand_window();
    for (int i = 0; i < 9; i++) data_in[i] = $urandom() >>> $urandom_range(0, 24);
    for (int i = 0; i < 9; i++) if ($urandom_range(0, 1) == 1) data_in[i] = -data_in[i];
  endtask

  task automatic stream_frame(input int n);
    for (int p = 0; p < n; p++) begin
      rand_window();
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      if ((p + 1) % 13 == 0) begin
        step();
        step();
      end
    end
  endtask

  function automatic logic [8:0][15:0] rand_weights();
    logic [8:0][15:0] w;
    for (int i = 0; i < 9; i++) w[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
    return w;
  endfunction

  vec_t vecs[$];

  initial begin
    vec_t             v;
    logic [8:0][15:0] wr;
    n_cmp = 0; n_err = 0; cyc = 0; n_valid = 0; n_fd = 0;
    w_data = '0; bias = '0; data_in = '0;
    do_reset();

    v.name = "unity_sum"; v.b = 0; v.expect_px = 45;
    for (int i = 0; i < 9; i++) begin v.w[i] = 16'd256; v.taps[i] = 32'(i + 1); end
    vecs.push_back(v);
    v.name = "relu_neg"; v.w = '0; v.w[0] = 16'hfe00; v.taps = '0; v.taps[0] = 32'd10;
    v.expect_px = 0;
    vecs.push_back(v);
    v.name = "neg_tap"; v.taps[0] = -32'sd10; v.expect_px = 20;
    vecs.push_back(v);
    v.name = "saturate";
    for (int i = 0; i < 9; i++) begin v.w[i] = 16'h7fff; v.taps[i] = 32'h7fff_ffff; end
    v.expect_px = 32'h7fff_ffff;
    vecs.push_back(v);
    v.name = "floor_frac"; v.w = '0; v.w[0] = 16'd128; v.taps = '0; v.taps[0] = 32'd3;
    v.expect_px = 1;
    vecs.push_back(v);
    v.name = "bias_pos"; v.b = 32'd100;
    for (int i = 0; i < 9; i++) begin v.w[i] = 16'd256; v.taps[i] = 32'd1; end
    v.expect_px = 109;
    vecs.push_back(v);
    v.name = "bias_neg"; v.b = -32'sd5; v.taps = '0; v.expect_px = 0;
    vecs.push_back(v);

    foreach (vecs[k]) begin
      bias = vecs[k].b;
      load(vecs[k].w, 9);
      data_in  = vecs[k].taps;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      step();
      step();
      check({vecs[k].name, " valid"}, 32'(valid_out), 32'd1);
      check(vecs[k].name, data_out, vecs[k].expect_px);
    end

    // Full frame with row gaps from a clean start.
    do_reset();
    bias = 32'($urandom_range(0, 200)) - 32'd100;
    load(rand_weights(), 9);
    n_valid = 0; n_fd = 0;
    stream_frame(FRAME);
    for (int i = 0; i < 5; i++) step();
    check("frame valid count", 32'(n_valid), 32'(FRAME));
    check("frame_done count", 32'(n_fd), 32'd1);

    // Partial load invalidates the kernel until a full reload.
    wr = rand_weights();
    load(wr, 5);
    n_valid = 0;
    stream_frame(4);
    for (int i = 0; i < 5; i++) step();
    check("partial load outputs", 32'(n_valid), 32'd0);
    load(wr, 9);
    stream_frame(5);
    for (int i = 0; i < 5; i++) step();
    check("reload outputs", 32'(n_valid), 32'd5);

    // Reset with pixels in flight mid-frame.
    stream_frame(20);
    step();
    do_reset();
    n_valid = 0;
    for (int i = 0; i < 4; i++) step();
    check("no output after reset", 32'(n_valid), 32'd0);
    load(rand_weights(), 9);
    n_valid = 0; n_fd = 0;
    stream_frame(FRAME - 1);
    for (int i = 0; i < 5; i++) step();
    check("no frame_done before last", 32'(n_fd), 32'd0);
    stream_frame(1);
    for (int i = 0; i < 5; i++) step();
    check("post-reset valid count", 32'(n_valid), 32'(FRAME));
    check("post-reset frame_done", 32'(n_fd), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
